element_delay_accumulator: RTL and testbench
============================================

# element_delay_accumulator

Consumer end of the increment-term handshake in the per-element delay pipeline. It captures the initial delay d_0 and takes one signed increment term K_n per element over a term_ready/term_ack handshake. It folds each term into a squared-delay error accumulator and runs an iterative integer square-root tracking loop, one step per cycle. It emits one integer sample delay per element to the downstream focusing logic over a delay_valid/delay_ack handshake.

## Interface
- DW_INTEGER, 18, integer bits of fixed-point operands
- DW_FRACTION, 3, fractional bits of fixed-point operands (F below)
- NUM_ELEMENTS, 32, delays emitted per initiate (element 0 = d_0, then NUM_ELEMENTS-1 terms consumed)
- MAX_STEPS, 63, step cap per element (only with ELEM_DELAY_STEP_LIMIT_EN)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- initiate  in  1  start a delay run; sampled only in IDLE
- d_0  in  DW_INTEGER+DW_FRACTION+1  unsigned fixed-point initial delay in samples; sampled in LOAD
- term_in  in  DW_INTEGER+DW_FRACTION+1  signed fixed-point K_n with F fractional bits; sample^2 units
- term_ready  in  1  term_in valid; producer holds term_in stable until term_ack
- term_ack  out  1  one-cycle pulse: term consumed
- delay_out  out  DW_INTEGER+1  integer sample delay of current element
- delay_valid  out  1  delay_out valid; held until delay_ack
- delay_ack  in  1  downstream has read delay_out
- element_idx  out  6  index of element on delay_out, 0..NUM_ELEMENTS-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last delay is acknowledged
- step_limit  out  1  sticky per run: some element hit MAX_STEPS

## Operation
- Registers: d (unsigned, DW_INTEGER+1 bits), E (signed, DW_INTEGER+DW_FRACTION+3 bits), step counter (6 bits), idx.
- Thresholds: TP = (2d+1)<<F and TN = (2d-1)<<F, computed at E width.
- FSM states: IDLE, LOAD, OUTPUT, WAIT_TERM, ACK, STEP.
- IDLE: all registers are cleared. initiate=1 moves to LOAD. Otherwise the FSM stays in IDLE.
- LOAD:
  - d <= d_0 >> F; fractional bits are truncated.
  - E <= 0, idx <= 0, step_limit <= 0.
  - Next state is OUTPUT.
- OUTPUT: delay_valid=1 and delay_out=d.
  - If delay_ack=1 and idx==NUM_ELEMENTS-1: go to IDLE and pulse done.
  - If delay_ack=1 otherwise: idx++ and go to WAIT_TERM.
- WAIT_TERM: if term_ready=1, E <= E + sign-extended term_in and go to ACK.
- ACK: term_ack=1 and step counter <= 0. Next state is STEP.
- STEP: one decision per cycle, evaluated in this priority order:
  - E >= TP and d < max: E <= E-TP, d++.
  - Otherwise, E <= -TN and d > 0: E <= E+TN, d--.
  - Otherwise (converged): go to OUTPUT.
  - If d saturates at either rail with the condition still true, treat it as converged.
- Converged window: -TN < E < TP. E is never cleared between elements; the residual carries forward.
- rst has priority everywhere. In the cycle after rst, all outputs are 0 and the state is IDLE.
- initiate is ignored outside IDLE. term_ready is ignored outside WAIT_TERM. delay_ack is ignored outside OUTPUT.

## Timing
- Reset value of every output is 0.
- Outputs are Moore, decoded from registered state and registers.
- Cycle references (relative to initiate sampled at cycle t):
  - LOAD at t+1.
  - OUTPUT at t+2, with delay_valid=1 and delay_out=d_0>>F.
- Per element, with term_ready high at cycle c in WAIT_TERM:
  - ACK at c+1 (term_ack=1).
  - STEP from c+2 for s+1 cycles, where s is the number of d adjustments.
  - OUTPUT at c+3+s.
- delay_ack sampled at cycle a in OUTPUT: WAIT_TERM (or IDLE, with done=1) at a+1.
- Both handshakes tolerate ready/ack held high indefinitely. Back-to-back elements need a minimum of 4 cycles.

## Configuration
- ELEM_DELAY_STEP_LIMIT_EN defined:
  - STEP counts adjustments. On reaching MAX_STEPS, STEP exits to OUTPUT with the current d and sets step_limit (sticky until LOAD/IDLE).
  - E keeps its unresolved residual.
- Not defined:
  - The loop runs until convergence or d saturation.
  - step_limit is tied to 0 and the step counter is removed.

## Test plan
- d_0=800 (100.0), term_in=+1608 -> term_ack at c+1; one increment; delay_out=101 at c+4; E=0.
- Continue with term_in=-1608 -> E=-1608 <= -TN(1608); one decrement; delay_out=100; E=0.
- d_0=400, 31 terms of 0 with delay_ack immediate -> 32 delays of 50, element_idx 0..31, done one cycle after the 32nd delay_ack, busy drops with it.
- d_0=0, term_in=+1048576 with macro, MAX_STEPS=63 -> delay_out=63, step_limit=1. Without macro -> delay_out=362.
- d_0=0, term_in=-80 -> no decrement at d=0; delay_out=0; E=-80 carried to the next element.
- rst asserted mid-STEP, and initiate pulsed while busy -> next cycle all outputs 0 and IDLE. The busy-time initiate does not start a run.

Source files
------------

// File: rtl/element_delay_accumulator.sv
// rtl/element_delay_accumulator.sv - per-element integer delay tracker fed by signed squared-delay increment terms
// Optional ELEM_DELAY_STEP_LIMIT_EN caps the square-root tracking loop at MAX_STEPS adjustments per element.
module element_delay_accumulator #(
    parameter int DW_INTEGER   = 18,
    parameter int DW_FRACTION  = 3,
    parameter int NUM_ELEMENTS = 32
`ifdef ELEM_DELAY_STEP_LIMIT_EN
    ,
    parameter int MAX_STEPS    = 63
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            initiate,
    input  logic [DW_INTEGER+DW_FRACTION:0] d_0,
    input  logic [DW_INTEGER+DW_FRACTION:0] term_in,
    input  logic                            term_ready,
    output logic                            term_ack,
    output logic [DW_INTEGER:0]             delay_out,
    output logic                            delay_valid,
    input  logic                            delay_ack,
    output logic [5:0]                      element_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            step_limit
);

    localparam int FW = DW_INTEGER + DW_FRACTION + 1;
    localparam int DW = DW_INTEGER + 1;
    localparam int EW = DW_INTEGER + DW_FRACTION + 3;

    localparam logic [DW-1:0]        D_MAX    = '1;
    localparam logic [DW-1:0]        D_ONE    = 1;
    localparam logic signed [EW-1:0] E_ONE    = 1;
    localparam logic [5:0]           LAST_IDX = 6'(NUM_ELEMENTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OUTPUT,
        S_WAIT_TERM,
        S_ACK,
        S_STEP
    } state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          d_q, d_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic [5:0]             idx_q, idx_d;
    logic                   done_q, done_d;
    logic                   adjust;
    logic                   cap_hit;

    logic signed [EW-1:0]   d_ext;
    logic signed [EW-1:0]   term_ext;
    logic signed [EW-1:0]   tp;
    logic signed [EW-1:0]   tn;

    // E holds (target squared delay - d^2) in F-bit fixed point; TP/TN are the cost of moving d by one.
    assign d_ext    = {{(EW-DW){1'b0}}, d_q};
    assign term_ext = {{(EW-FW){term_in[FW-1]}}, term_in};
    assign tp       = ((d_ext <<< 1) + E_ONE) <<< DW_FRACTION;
    assign tn       = ((d_ext <<< 1) - E_ONE) <<< DW_FRACTION;

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        e_d     = e_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        adjust  = 1'b0;
        case (state_q)
            S_IDLE: begin
                d_d   = '0;
                e_d   = '0;
                idx_d = '0;
                if (initiate) state_d = S_LOAD;
            end
            S_LOAD: begin
                d_d     = DW'(d_0 >> DW_FRACTION);
                e_d     = '0;
                idx_d   = '0;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (delay_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_WAIT_TERM;
                    end
                end
            end
            S_WAIT_TERM: begin
                if (term_ready) begin
                    e_d     = e_q + term_ext;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_STEP;
            end
            S_STEP: begin
                // A rail-blocked move counts as converged; the residual stays in E for the next element.
                if (cap_hit) begin
                    state_d = S_OUTPUT;
                end else if (e_q >= tp && d_q != D_MAX) begin
                    e_d    = e_q - tp;
                    d_d    = d_q + D_ONE;
                    adjust = 1'b1;
                end else if (e_q <= -tn && d_q != '0) begin
                    e_d    = e_q + tn;
                    d_d    = d_q - D_ONE;
                    adjust = 1'b1;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            e_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

`ifdef ELEM_DELAY_STEP_LIMIT_EN
    logic [5:0] step_cnt_q, step_cnt_d;
    logic       step_limit_q, step_limit_d;

    assign cap_hit = (step_cnt_q == 6'(MAX_STEPS));

    always_comb begin
        step_cnt_d   = step_cnt_q;
        step_limit_d = step_limit_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                step_cnt_d   = '0;
                step_limit_d = 1'b0;
            end
            S_ACK: begin
                step_cnt_d = '0;
            end
            S_STEP: begin
                if (cap_hit) step_limit_d = 1'b1;
                else if (adjust) step_cnt_d = step_cnt_q + 6'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q   <= '0;
            step_limit_q <= 1'b0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            step_limit_q <= step_limit_d;
        end
    end

    assign step_limit = step_limit_q;
`else
    assign cap_hit    = 1'b0;
    assign step_limit = 1'b0;
`endif

    assign term_ack    = (state_q == S_ACK);
    assign delay_valid = (state_q == S_OUTPUT);
    assign delay_out   = d_q;
    assign element_idx = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_element_delay_accumulator.sv
// tb/tb_element_delay_accumulator.sv - randomized self-checking bench for element_delay_accumulator
module tb_element_delay_accumulator;

    localparam int     NUM_EL = 32;
    localparam int     CAP    = 63;
    localparam longint D_MAX  = (64'd1 << 19) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        initiate = 1'b0;
    logic        term_ready = 1'b0;
    logic        delay_ack = 1'b0;
    logic [21:0] d_0 = '0;
    logic [21:0] term_in = '0;
    logic        term_ack, delay_valid, busy, done, step_limit;
    logic [18:0] delay_out;
    logic [5:0]  element_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    element_delay_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .initiate    (initiate),
        .d_0         (d_0),
        .term_in     (term_in),
        .term_ready  (term_ready),
        .term_ack    (term_ack),
        .delay_out   (delay_out),
        .delay_valid (delay_valid),
        .delay_ack   (delay_ack),
        .element_idx (element_idx),
        .busy        (busy),
        .done        (done),
        .step_limit  (step_limit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1);
    end

    // Reference: T = E + 8*d^2 is the target squared delay; d tracks floor-ish sqrt(T/8) one unit per step.
    longint m_d, m_t;
    bit     m_lim;

    task automatic model_start(input longint d0);
        m_d   = d0 >> 3;
        m_t   = 8 * m_d * m_d;
        m_lim = 0;
    endtask

    task automatic model_term(input longint term, output int s);
        m_t += term;
        s = 0;
        while (1) begin
`ifdef ELEM_DELAY_STEP_LIMIT_EN
            if (s == CAP) begin m_lim = 1; break; end
`endif
            if (m_t >= 8 * (m_d + 1) * (m_d + 1) && m_d < D_MAX) begin m_d++; s++; end
            else if (m_d > 0 && m_t <= 8 * (m_d - 1) * (m_d - 1)) begin m_d--; s++; end
            else break;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; initiate = 0; term_ready = 0; delay_ack = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic start_run(input logic [21:0] d0);
        d_0 = d0; initiate = 1;
        tick();
        initiate = 0;
        tick();
    endtask

    task automatic ack_delay();
        delay_ack = 1;
        tick();
        delay_ack = 0;
    endtask

    // n = cycles from the term_ready cycle c until delay_valid is seen again (c+3+s)
    task automatic send_term(input logic [21:0] term, output logic acked, output int n);
        term_in = term; term_ready = 1;
        tick();
        acked = term_ack;
        term_ready = 0;
        n = 1;
        while (!delay_valid && n < 400) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst = 1; initiate = 1;
        tick();
        n_checks++;
        if ({term_ack, delay_valid, busy, done, step_limit, delay_out, element_idx} !== 30'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required 0", {term_ack, delay_valid, busy, done, step_limit, delay_out, element_idx});
        end
        tick();
        rst = 0; initiate = 0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_single_step();
        logic acked; int n;
        start_run(22'd800);
        n_checks++; if (delay_valid !== 1'b1) begin n_errors++; $display("FAIL first_valid: got %b required 1", delay_valid); end
        n_checks++; if (delay_out !== 19'd100) begin n_errors++; $display("FAIL first_delay: got %0d required 100", delay_out); end
        n_checks++; if (element_idx !== 6'd0) begin n_errors++; $display("FAIL first_idx: got %0d required 0", element_idx); end
        ack_delay();
        n_checks++; if (delay_valid !== 1'b0) begin n_errors++; $display("FAIL wait_valid: got %b required 0", delay_valid); end
        send_term(22'd1608, acked, n);
        n_checks++; if (acked !== 1'b1) begin n_errors++; $display("FAIL up_term_ack: got %b required 1", acked); end
        n_checks++; if (n !== 4) begin n_errors++; $display("FAIL up_latency: got %0d required 4", n); end
        n_checks++; if (delay_out !== 19'd101) begin n_errors++; $display("FAIL up_delay: got %0d required 101", delay_out); end
        n_checks++; if (element_idx !== 6'd1) begin n_errors++; $display("FAIL up_idx: got %0d required 1", element_idx); end
        ack_delay();
        send_term(22'(-1608), acked, n);
        n_checks++; if (n !== 4) begin n_errors++; $display("FAIL down_latency: got %0d required 4", n); end
        n_checks++; if (delay_out !== 19'd100) begin n_errors++; $display("FAIL down_delay: got %0d required 100", delay_out); end
        ack_delay();
        send_term(22'd0, acked, n);
        n_checks++; if (n !== 3) begin n_errors++; $display("FAIL zero_residual_latency: got %0d required 3", n); end
        n_checks++; if (delay_out !== 19'd100) begin n_errors++; $display("FAIL zero_residual_delay: got %0d required 100", delay_out); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        int count = 0;
        int last = -1;
        int done_cyc = -1;
        d_0 = 22'd400; term_in = '0; term_ready = 1; delay_ack = 1; initiate = 1;
        tick();
        initiate = 0;
        for (int k = 0; k < 300 && done_cyc < 0; k++) begin
            tick();
            if (delay_valid) begin
                n_checks++; if (delay_out !== 19'd50) begin n_errors++; $display("FAIL b2b_delay: got %0d required 50", delay_out); end
                n_checks++; if (element_idx !== 6'(count)) begin n_errors++; $display("FAIL b2b_idx: got %0d required %0d", element_idx, count); end
                if (count > 0) begin
                    n_checks++; if (cyc - last !== 4) begin n_errors++; $display("FAIL b2b_spacing: got %0d required 4", cyc - last); end
                end
                last = cyc;
                count++;
            end
            if (done) begin
                done_cyc = cyc;
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy_at_done: got %b required 0", busy); end
                n_checks++; if (done_cyc !== last + 1) begin n_errors++; $display("FAIL b2b_done_timing: got %0d required %0d", done_cyc, last + 1); end
            end
        end
        n_checks++; if (count !== NUM_EL) begin n_errors++; $display("FAIL b2b_count: got %0d required %0d", count, NUM_EL); end
        n_checks++; if (done_cyc === -1) begin n_errors++; $display("FAIL b2b_done_seen: got none required one pulse"); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_pulse: got %b required 0", done); end
        term_ready = 0; delay_ack = 0;
        do_reset();
    endtask

    task automatic test_saturation_cap();
        logic acked; int n;
        int exp_d, exp_n;
        logic exp_lim;
`ifdef ELEM_DELAY_STEP_LIMIT_EN
        exp_d = 63; exp_n = 3 + 63; exp_lim = 1'b1;
`else
        exp_d = 362; exp_n = 3 + 362; exp_lim = 1'b0;
`endif
        start_run(22'd0);
        ack_delay();
        send_term(22'd1048576, acked, n);
        n_checks++; if (delay_out !== 19'(exp_d)) begin n_errors++; $display("FAIL big_term_delay: got %0d required %0d", delay_out, exp_d); end
        n_checks++; if (n !== exp_n) begin n_errors++; $display("FAIL big_term_latency: got %0d required %0d", n, exp_n); end
        n_checks++; if (step_limit !== exp_lim) begin n_errors++; $display("FAIL big_term_step_limit: got %b required %b", step_limit, exp_lim); end
        do_reset();
    endtask

    task automatic test_floor_at_zero();
        logic acked; int n;
        start_run(22'd0);
        ack_delay();
        send_term(22'(-80), acked, n);
        n_checks++; if (delay_out !== 19'd0) begin n_errors++; $display("FAIL floor_delay: got %0d required 0", delay_out); end
        n_checks++; if (n !== 3) begin n_errors++; $display("FAIL floor_latency: got %0d required 3", n); end
        ack_delay();
        send_term(22'd88, acked, n);
        n_checks++; if (delay_out !== 19'd1) begin n_errors++; $display("FAIL carry_delay: got %0d required 1", delay_out); end
        n_checks++; if (n !== 4) begin n_errors++; $display("FAIL carry_latency: got %0d required 4", n); end
        do_reset();
    endtask

    task automatic test_initiate_while_busy();
        start_run(22'd800);
        ack_delay();
        d_0 = 22'd1600; initiate = 1;
        tick();
        initiate = 0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL busy_initiate_busy: got %b required 1", busy); end
        n_checks++; if (element_idx !== 6'd1) begin n_errors++; $display("FAIL busy_initiate_idx: got %0d required 1", element_idx); end
        term_in = 22'd1048576; term_ready = 1;
        tick();
        term_ready = 0;
        tick(); tick(); tick();
        initiate = 1; rst = 1;
        tick();
        n_checks++;
        if ({term_ack, delay_valid, busy, done, step_limit, delay_out, element_idx} !== 30'd0) begin
            n_errors++;
            $display("FAIL mid_step_reset: got %h required 0", {term_ack, delay_valid, busy, done, step_limit, delay_out, element_idx});
        end
        rst = 0; initiate = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle: got %b required 0", busy); end
        end
    endtask

    task automatic test_random_runs();
        logic acked; int n, s, term;
        logic [21:0] d0;
        for (int r = 0; r < 4; r++) begin
            d0 = 22'($urandom_range(0, 32767));
            model_start(longint'(d0));
            start_run(d0);
            n_checks++; if (delay_out !== 19'(m_d)) begin n_errors++; $display("FAIL rand_first_delay: got %0d required %0d", delay_out, m_d); end
            for (int e = 1; e < NUM_EL; e++) begin
                repeat ($urandom_range(0, 2)) tick();
                n_checks++; if (delay_valid !== 1'b1) begin n_errors++; $display("FAIL rand_valid_hold: got %b required 1", delay_valid); end
                ack_delay();
                repeat ($urandom_range(0, 2)) tick();
                term = int'($urandom_range(0, 32767)) - 16384;
                model_term(longint'(term), s);
                send_term(22'(term), acked, n);
                n_checks++; if (acked !== 1'b1) begin n_errors++; $display("FAIL rand_term_ack: got %b required 1", acked); end
                n_checks++; if (n !== 3 + s) begin n_errors++; $display("FAIL rand_latency: got %0d required %0d", n, 3 + s); end
                n_checks++; if (delay_out !== 19'(m_d)) begin n_errors++; $display("FAIL rand_delay: got %0d required %0d", delay_out, m_d); end
                n_checks++; if (element_idx !== 6'(e)) begin n_errors++; $display("FAIL rand_idx: got %0d required %0d", element_idx, e); end
                n_checks++; if (step_limit !== m_lim) begin n_errors++; $display("FAIL rand_step_limit: got %b required %b", step_limit, m_lim); end
            end
            ack_delay();
            n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rand_done: got %b required 1", done); end
            n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rand_busy_end: got %b required 0", busy); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_back_to_back();
        test_saturation_cap();
        test_floor_at_zero();
        test_random_runs();
        test_initiate_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
